mcp3008_responder: RTL and testbench

- SPI responder that emulates an MCP3008 10-bit, 8-channel ADC, driven by the motor-controller's existing ADC polling master (AD_CLK/CS/DIN/DOUT).
- Serves per-channel sample values from a parallel input bus.
- Used as a closed-loop bench model for the controller and as a drop-in on a second board with no physical ADC.
- Runs on the system clock and oversamples the SPI pins; it does not clock logic on SCLK.

---
 rtl/mcp3008_responder.sv | 140 ++++++++++++++
 tb/tb_mcp3008_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3008_responder.sv
// MCP3008-compatible SPI responder: oversamples AD_CLK/CS/DIN on clk and
// answers conversions with 10-bit samples taken from a parallel channel bus.
module mcp3008_responder #(
  parameter int SYNC_STAGES = 2,     // >= 2
  parameter bit ZERO_FILL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic [79:0] ch_data,
  output logic        conv_done,
  output logic [2:0]  conv_chan,
  output logic        conv_sgl,
  output logic [9:0]  conv_value
);
  localparam int S = SYNC_STAGES;
  localparam logic [2:0] IDLE = 3'd0, WAIT_START = 3'd1, CMD = 3'd2, SAMPLE = 3'd3,
                         MSB = 3'd4, LSB = 3'd5, TAIL = 3'd6;

  logic [S-1:0] sclk_sync, cs_sync, din_sync, sync_vld;
  logic         sclk_q, sclk_s, cs_s, din_s, sync_ok, rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      din_sync  <= '0;
      sync_vld  <= '0;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[S-2:0], sclk};
      cs_sync   <= {cs_sync[S-2:0], cs_n};
      din_sync  <= {din_sync[S-2:0], din};
      sync_vld  <= {sync_vld[S-2:0], 1'b1};
      sclk_q    <= sclk_s;
    end
  end

  assign sclk_s  = sclk_sync[S-1];
  assign cs_s    = cs_sync[S-1];
  assign din_s   = din_sync[S-1];
  // sync_ok marks that the chain holds only post-reset pin samples, so the
  // reset value of cs_sync is never taken as a real CS deassertion.
  assign sync_ok = sync_vld[S-1];
  assign rise    = sync_ok & sclk_s & ~sclk_q;
  assign fall    = sync_ok & ~sclk_s & sclk_q;

  logic [2:0] state;
  logic [3:0] cnt, cmd;        // cmd = {SGL, D2, D1, D0}
  logic [9:0] val, snap, se_val, ch_a, ch_b;
  logic [10:0] diff;
  logic       armed;

  assign se_val = ch_data[10*int'(cmd[2:0]) +: 10];
  assign ch_a   = ch_data[20*int'(cmd[2:1]) +: 10];
  assign ch_b   = ch_data[20*int'(cmd[2:1]) + 10 +: 10];
  assign diff   = cmd[0] ? ({1'b0, ch_b} - {1'b0, ch_a}) : ({1'b0, ch_a} - {1'b0, ch_b});
  assign snap   = cmd[3] ? se_val : (diff[10] ? 10'd0 : diff[9:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd        <= '0;
      val        <= '0;
      armed      <= 1'b0;
      dout       <= 1'b0;
      dout_oe    <= 1'b0;
      conv_done  <= 1'b0;
      conv_chan  <= '0;
      conv_sgl   <= 1'b0;
      conv_value <= '0;
    end else begin
      conv_done <= 1'b0;
      if (cs_s) begin
        state   <= IDLE;
        dout    <= 1'b0;
        dout_oe <= 1'b0;
        armed   <= sync_ok;
      end else begin
        case (state)
          IDLE: if (armed) begin
            state <= WAIT_START;
            armed <= 1'b0;
          end
          WAIT_START: if (rise && din_s) begin
            state <= CMD;
            cnt   <= '0;
          end
          CMD: if (rise) begin
            cmd <= {cmd[2:0], din_s};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd3) begin
              state <= SAMPLE;
              cnt   <= '0;
            end
          end
          // first fall captures the sample, second fall is the null bit
          SAMPLE: if (fall) begin
            dout <= 1'b0;
            if (cnt == 4'd0) begin
              val     <= snap;
              dout_oe <= 1'b1;
              cnt     <= 4'd1;
            end else begin
              state <= MSB;
              cnt   <= '0;
            end
          end
          MSB: if (fall) begin
            dout <= val[4'd9 - cnt];
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd9) begin
              conv_done  <= 1'b1;
              conv_chan  <= cmd[2:0];
              conv_sgl   <= cmd[3];
              conv_value <= val;
              state      <= LSB;
              cnt        <= '0;
            end
          end
          LSB: if (fall) begin
            dout <= val[cnt + 4'd1];
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd8) state <= TAIL;
          end
          TAIL: if (fall) begin
            dout <= 1'b0;
            if (!ZERO_FILL) dout_oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mcp3008_responder.sv
// Bench for mcp3008_responder: SPI master model driving two instances
// (zero-fill and release tails), checked against a spec-level response model.
module tb_mcp3008_responder;
  localparam int S = 2;

  logic clk = 1'b0, rst_n, sclk, cs_n, din;
  logic [79:0] ch_data;
  logic dout0, oe0, done0, sgl0, dout1, oe1, done1, sgl1;
  logic [2:0] chan0, chan1;
  logic [9:0] val0, val1;

  int nvec = 0, nerr = 0, done_cnt0 = 0, done_cnt1 = 0;
  logic [2:0] last_chan = '0;
  logic       last_sgl  = 1'b0;
  logic [9:0] last_val  = '0;

  always #10 clk = ~clk;

  mcp3008_responder #(.SYNC_STAGES(S), .ZERO_FILL(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .din(din),
    .dout(dout0), .dout_oe(oe0), .ch_data(ch_data), .conv_done(done0),
    .conv_chan(chan0), .conv_sgl(sgl0), .conv_value(val0));

  mcp3008_responder #(.SYNC_STAGES(S), .ZERO_FILL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .din(din),
    .dout(dout1), .dout_oe(oe1), .ch_data(ch_data), .conv_done(done1),
    .conv_chan(chan1), .conv_sgl(sgl1), .conv_value(val1));

  always @(negedge clk) begin
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  typedef struct {
    logic [79:0] ch;
    logic [3:0]  cmd;
    int          lead;
    logic [9:0]  expv;
  } vec_t;
  vec_t tbl[6];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Converted value from the datasheet rules, in plain integer arithmetic.
  function automatic logic [9:0] model(input logic [79:0] ch, input logic [3:0] cmd);
    int c, a, b, v;
    logic [31:0] r;
    c = int'(cmd[2:0]);
    if (cmd[3]) return ch[c*10 +: 10];
    a = int'(ch[(c/2)*20 +: 10]);
    b = int'(ch[(c/2)*20 + 10 +: 10]);
    v = cmd[0] ? b - a : a - b;
    if (v < 0) v = 0;
    r = 32'(v);
    return r[9:0];
  endfunction

  // Expected pad state after fall Fj: nothing before F4, zeros at F4/F5,
  // MSB-first B9..B0 at F6..F15, B1..B9 at F16..F24, then the tail.
  task automatic check_bit(input int j, input logic [9:0] expv, input logic [3:0] smp);
    logic eoe, eoe1, ed;
    logic [3:0] act, exp;
    eoe  = (j >= 4);
    eoe1 = (j >= 4) && (j < 25);
    ed   = 1'b0;
    if (j >= 6 && j <= 15) ed = expv[15-j];
    else if (j >= 16 && j <= 24) ed = expv[j-15];
    act = {smp[3:1], (j >= 25) ? 1'b0 : smp[0]};
    exp = {eoe, ed, eoe1, (j >= 25) ? 1'b0 : ed};
    chk($sformatf("bit_F%0d", j), 32'(act), 32'(exp));
  endtask

  // One SCLK period; samples {oe0,dout0,oe1,dout1} just before the fall.
  task automatic cyc(input logic d, input int half, output logic [3:0] smp);
    din = d;
    wait_clk(half);
    sclk = 1'b1;
    wait_clk(half);
    smp  = {oe0, dout0, oe1, dout1};
    sclk = 1'b0;
  endtask

  task automatic frame(input int lead, input logic [3:0] cmd, input logic [9:0] expv,
                       input int ncyc, input int abort_k, input int chg_k,
                       input logic [79:0] chg_val, input int rst_k, input int half);
    logic [3:0] smp;
    logic dbit;
    int d0, d1;
    bit stop;
    stop = 1'b0;
    d0 = done_cnt0;
    d1 = done_cnt1;
    cs_n = 1'b0;
    wait_clk(S + 3);
    for (int i = 0; i < lead; i++) cyc(1'b0, half, smp);
    for (int k = 0; k < ncyc && !stop; k++) begin
      dbit = (k == 0) ? 1'b1 : (k <= 4) ? cmd[4-k] : 1'($urandom);
      cyc(dbit, half, smp);
      if (k >= 1) check_bit(k - 1, expv, smp);
      else chk("lead_oe", {30'd0, smp[3], smp[1]}, 32'd0);
      if (k == chg_k) ch_data = chg_val;
      if (k == abort_k) begin
        stop = 1'b1;
        cs_n = 1'b1;
        wait_clk(S + 1);
        chk("abort_oe", {29'd0, oe0, oe1, dout0}, 32'd0);
        wait_clk(4);
        chk("abort_done", 32'(done_cnt0 - d0 + done_cnt1 - d1), 32'd0);
        chk("abort_conv", {18'd0, chan0, sgl0, val0}, {18'd0, last_chan, last_sgl, last_val});
      end
      if (k == rst_k) begin
        stop  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid0", {14'd0, dout0, oe0, done0, chan0, sgl0, val0}, 32'd0);
        chk("rst_mid1", {14'd0, dout1, oe1, done1, chan1, sgl1, val1}, 32'd0);
        wait_clk(2);
        rst_n = 1'b1;
        last_chan = '0;
        last_sgl  = 1'b0;
        last_val  = '0;
      end
    end
    if (!stop) begin
      wait_clk(half);
      check_bit(ncyc - 1, expv, {oe0, dout0, oe1, dout1});
      chk("done_cnt", 32'(done_cnt0 - d0), 32'd1);
      chk("done_cnt1", 32'(done_cnt1 - d1), 32'd1);
      chk("conv", {18'd0, chan0, sgl0, val0}, {18'd0, cmd[2:0], cmd[3], expv});
      chk("conv1", {22'd0, val1}, {22'd0, expv});
      last_chan = cmd[2:0];
      last_sgl  = cmd[3];
      last_val  = expv;
      cs_n = 1'b1;
      wait_clk(S + 2);
      chk("cs_hi_oe", {30'd0, oe0, oe1}, 32'd0);
    end
  endtask

  initial begin
    logic [79:0] ch, ch2;
    logic [3:0]  cmd, smp;
    logic [9:0]  e;
    int dsave;

    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; din = 1'b0; ch_data = '0;
    wait_clk(3);
    chk("reset0", {14'd0, dout0, oe0, done0, chan0, sgl0, val0}, 32'd0);
    chk("reset1", {14'd0, dout1, oe1, done1, chan1, sgl1, val1}, 32'd0);
    rst_n = 1'b1;
    wait_clk(6);

    tbl[0].ch = '0; tbl[0].ch[50 +: 10] = 10'h2A5; tbl[0].ch[40 +: 10] = 10'h3FF;
    tbl[0].cmd = 4'b1101; tbl[0].lead = 8; tbl[0].expv = 10'h2A5;
    tbl[1].ch = '0; tbl[1].ch[0 +: 10] = 10'd300; tbl[1].ch[10 +: 10] = 10'd100;
    tbl[1].ch[20 +: 10] = 10'd7;
    tbl[1].cmd = 4'b0000; tbl[1].lead = 2; tbl[1].expv = 10'd200;
    tbl[2].ch = tbl[1].ch; tbl[2].cmd = 4'b0001; tbl[2].lead = 0; tbl[2].expv = 10'd0;
    tbl[3].ch = '0; tbl[3].ch[30 +: 10] = 10'h201; tbl[3].ch[20 +: 10] = 10'h0F0;
    tbl[3].ch[40 +: 10] = 10'h1C3;
    tbl[3].cmd = 4'b1011; tbl[3].lead = 0; tbl[3].expv = 10'h201;
    tbl[4].ch = '0; tbl[4].ch[60 +: 10] = 10'd10; tbl[4].ch[70 +: 10] = 10'd1023;
    tbl[4].cmd = 4'b0111; tbl[4].lead = 3; tbl[4].expv = 10'd1013;
    tbl[5].ch = tbl[4].ch; tbl[5].cmd = 4'b0110; tbl[5].lead = 1; tbl[5].expv = 10'd0;

    for (int i = 0; i < 6; i++) begin
      ch_data = tbl[i].ch;
      frame(tbl[i].lead, tbl[i].cmd, tbl[i].expv, 28, -1, -1, '0, -1, 6);
      wait_clk(4);
    end

    // abort after F10, then a clean frame
    ch = {$urandom, $urandom, $urandom};
    ch_data = ch;
    frame(1, 4'b1010, model(ch, 4'b1010), 28, 10, -1, '0, -1, 6);
    wait_clk(4);
    frame(0, 4'b1010, model(ch, 4'b1010), 26, -1, -1, '0, -1, 6);
    wait_clk(4);

    // ch_data change in flight must not disturb the word
    ch = '0; ch[20 +: 10] = 10'h155;
    ch2 = '0; ch2[20 +: 10] = 10'h0AA;
    ch_data = ch;
    frame(2, 4'b1010, 10'h155, 26, -1, 8, ch2, -1, 5);
    wait_clk(4);
    frame(0, 4'b1010, 10'h0AA, 26, -1, -1, '0, -1, 5);
    wait_clk(4);

    // reset at F9 with CS held low: silent until CS toggles
    ch = '0; ch[10 +: 10] = 10'h3C3;
    ch_data = ch;
    dsave = done_cnt0;
    frame(0, 4'b1001, 10'h3C3, 28, -1, -1, '0, 9, 6);
    wait_clk(4);
    for (int k = 0; k < 20; k++) begin
      cyc((k < 5) ? 1'b1 : 1'($urandom), 6, smp);
      chk($sformatf("post_rst_oe%0d", k), {30'd0, smp[3], smp[1]}, 32'd0);
    end
    wait_clk(6);
    chk("post_rst_done", 32'(done_cnt0 - dsave), 32'd0);
    chk("post_rst_val", {22'd0, val0}, 32'd0);
    cs_n = 1'b1;
    wait_clk(S + 3);
    frame(1, 4'b1001, 10'h3C3, 26, -1, -1, '0, -1, 6);
    wait_clk(4);

    for (int n = 0; n < 16; n++) begin
      ch  = {$urandom, $urandom, $urandom};
      cmd = 4'($urandom);
      ch_data = ch;
      e = model(ch, cmd);
      frame(int'($urandom_range(0, 8)), cmd, e, int'($urandom_range(26, 28)),
            -1, -1, '0, -1, int'($urandom_range(S + 2, 7)));
      wait_clk(int'($urandom_range(1, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
